bcd_countdown_timer: RTL and testbench
======================================

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 Parameter TICK_DIV, default 100000000: clk cycles per one-second tick; legal range >= 2.
REQ-002 Parameter MIN_DIGITS, default 2: number of BCD minute digits; legal range 1..4.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port load  input  1  capture load_min/load_sec as the new preset and current time.
REQ-006 Port load_min  input  4*MIN_DIGITS  BCD minutes, most-significant digit in the top nibble.
REQ-007 Port load_sec  input  8  BCD seconds: tens in [7:4], units in [3:0].
REQ-008 Port start  input  1  begin or resume counting.
REQ-009 Port pause  input  1  suspend counting.
REQ-010 Port auto_reload  input  1  on expiry, restart from the preset instead of stopping.
REQ-011 Port digits  output  4*(MIN_DIGITS+2)  current time as BCD: minutes in the top nibbles, seconds in [7:0].
REQ-012 Port running  output  1  high only in state RUN.
REQ-013 Port done  output  1  high only in state DONE.
REQ-014 Port done_pulse  output  1  single-cycle strobe on each expiry.
REQ-015 Port error  output  1  high only in state ERROR.

Function
REQ-016 The block SHALL implement states IDLE, RUN, PAUSED, DONE and ERROR; all outputs SHALL be registered.
REQ-017 Input priority SHALL be reset > load > pause > start > tick.
REQ-018 A load in any state SHALL be validated: every minute nibble <= 9, sec units <= 9, sec tens <= 5.
REQ-019 A valid load SHALL write the preset and digits, clear the prescaler, and enter IDLE.
REQ-020 An invalid load SHALL set digits to all zero, leave the preset unchanged, and enter ERROR.
REQ-021 ERROR SHALL be left only by reset or a valid load; start is ignored in ERROR.
REQ-022 start in IDLE with non-zero digits SHALL enter RUN on the next edge.
REQ-023 start in IDLE with all-zero digits SHALL enter DONE and assert done_pulse on the same edge.
REQ-024 The prescaler SHALL count 0..TICK_DIV-1 only in RUN and wrap to 0; a tick SHALL occur on the cycle the prescaler equals TICK_DIV-1.
REQ-025 pause in RUN SHALL enter PAUSED with the prescaler frozen; start in PAUSED SHALL resume RUN from the frozen prescaler value.
REQ-026 On each tick the time SHALL decrement by one second with BCD borrow:
  - sec units 0->9 with a borrow;
  - sec tens 0->5 with a borrow;
  - each minute digit 0->9 with a borrow to the next digit up.
REQ-027 A tick that makes digits all zero SHALL assert done_pulse on that edge, and:
  - with auto_reload=0, SHALL enter DONE and hold digits at zero;
  - with auto_reload=1, SHALL reload digits from the preset on the following edge, stay in RUN, clear the prescaler, and not assert done.
REQ-028 DONE SHALL hold until a load or reset; start and pause are ignored in DONE.
REQ-029 pause and start asserted together in RUN SHALL enter PAUSED.
REQ-030 A load asserted on a tick cycle SHALL take effect, and the decrement SHALL be discarded.
REQ-031 A preset of all zero with auto_reload=1 SHALL enter DONE, never loop.
REQ-032 Minutes SHALL not wrap: at full scale (all 9s, 59 s) the counter only counts down.

Reset
REQ-033 On a reset cycle the block SHALL apply the following on the next edge:
  - state IDLE;
  - digits, preset and prescaler all zero;
  - running, done, done_pulse and error all 0.
REQ-034 Reset asserted mid-count SHALL abort immediately; no done_pulse SHALL be emitted.

Verification (TICK_DIV=4, MIN_DIGITS=2)
REQ-035 Load 00:03, start -> running=1; digits 00:02, 00:01, 00:00 at 4-cycle spacing; done_pulse once with digits 00:00; then done=1, running=0.
REQ-036 Load 10:00, start, one tick -> digits 09:59.
REQ-037 Load 01:70 -> error=1 and digits 00:00; start ignored; then load 00:05 -> error=0, IDLE, digits 00:05.
REQ-038 Load 00:02, auto_reload=1, start -> done_pulse every 2 ticks, digits cycle 00:01, 00:00, 00:02; done stays 0.
REQ-039 Load 00:05, start, pause after 2 cycles, hold 10 cycles, start -> first decrement exactly 2 cycles after resume.
REQ-040 Load 00:05, start, reset during third tick cycle -> all outputs 0, digits 00:00, no done_pulse.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// BCD minutes:seconds countdown timer with a one-second prescaler, pause/resume,
// load validation and optional auto-reload from the last valid preset.
module bcd_countdown_timer #(
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned MIN_DIGITS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [4*MIN_DIGITS-1:0]       load_min,
  input  logic [7:0]                    load_sec,
  input  logic                          start,
  input  logic                          pause,
  input  logic                          auto_reload,
  output logic [4*(MIN_DIGITS+2)-1:0]   digits,
  output logic                          running,
  output logic                          done,
  output logic                          done_pulse,
  output logic                          error
);

  localparam int unsigned NDIG    = MIN_DIGITS + 2;
  localparam int unsigned DIG_W   = 4 * NDIG;
  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_DONE,
    S_ERROR
  } state_t;

  state_t               state, state_nx;
  logic [DIG_W-1:0]     digits_nx;
  logic [DIG_W-1:0]     preset, preset_nx;
  logic [PRESC_W-1:0]   presc, presc_nx;
  logic                 reload_pend, reload_nx;
  logic                 pulse_nx;
  logic                 tick;
  logic                 load_ok;
  logic [DIG_W-1:0]     load_word;
  logic [DIG_W-1:0]     dec_val;

  // Digit 1 is the seconds-tens position (0..5); every other digit is 0..9.
  function automatic logic bcd_valid(input logic [DIG_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (v[4*i +: 4] > ((i == 1) ? 4'd5 : 4'd9)) ok = 1'b0;
    end
    return ok;
  endfunction

  // One-second decrement with a borrow ripple through the digit chain.
  function automatic logic [DIG_W-1:0] bcd_dec(input logic [DIG_W-1:0] v);
    logic [DIG_W-1:0] r;
    logic             borrow;
    r      = v;
    borrow = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign load_word = {load_min, load_sec};
  assign load_ok   = bcd_valid(load_word);
  assign tick      = (state == S_RUN) && (presc == PRESC_MAX);
  assign dec_val   = bcd_dec(digits);

  // State and datapath registers; status flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      digits      <= '0;
      preset      <= '0;
      presc       <= '0;
      reload_pend <= 1'b0;
      done_pulse  <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_nx;
      digits      <= digits_nx;
      preset      <= preset_nx;
      presc       <= presc_nx;
      reload_pend <= reload_nx;
      done_pulse  <= pulse_nx;
      running     <= (state_nx == S_RUN);
      done        <= (state_nx == S_DONE);
      error       <= (state_nx == S_ERROR);
    end
  end

  // Next-state logic; priority is load > pending reload > pause > start > tick.
  always_comb begin
    state_nx  = state;
    digits_nx = digits;
    preset_nx = preset;
    presc_nx  = presc;
    reload_nx = 1'b0;
    pulse_nx  = 1'b0;

    if (load) begin
      if (load_ok) begin
        preset_nx = load_word;
        digits_nx = load_word;
        presc_nx  = '0;
        state_nx  = S_IDLE;
      end else begin
        digits_nx = '0;
        state_nx  = S_ERROR;
      end
    end else if (reload_pend) begin
      // Expiry already pulsed on the previous edge; restore the preset here.
      if (preset == '0) begin
        digits_nx = '0;
        state_nx  = S_DONE;
      end else begin
        digits_nx = preset;
        presc_nx  = '0;
        state_nx  = pause ? S_PAUSED : S_RUN;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (!pause && start) begin
            if (digits == '0) begin
              state_nx = S_DONE;
              pulse_nx = 1'b1;
            end else begin
              state_nx = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (pause) begin
            state_nx = S_PAUSED;
          end else if (tick) begin
            presc_nx  = '0;
            digits_nx = dec_val;
            if (dec_val == '0) begin
              pulse_nx = 1'b1;
              if (auto_reload) reload_nx = 1'b1;
              else             state_nx  = S_DONE;
            end
          end else begin
            presc_nx = presc + PRESC_W'(1);
          end
        end
        S_PAUSED: begin
          if (!pause && start) state_nx = S_RUN;
        end
        S_DONE:  ;
        S_ERROR: ;
        default: state_nx = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: directed scenarios plus randomized
// stimulus compared against a seconds-arithmetic reference model.
module tb_bcd_countdown_timer;

  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned MIN_DIGITS = 2;
  localparam int TDIV = 4;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3, M_ERROR = 4;

  logic        clk = 1'b0;
  logic        reset, load, start, pause, auto_reload;
  logic [7:0]  load_min, load_sec;
  logic [15:0] digits;
  logic        running, done, done_pulse, error;

  int checks = 0;
  int errors = 0;

  // Reference model: time held as plain minutes/seconds integers.
  int m_state, m_min, m_sec, p_min, p_sec, m_cnt;
  bit m_reload, m_pulse;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.TICK_DIV(TICK_DIV), .MIN_DIGITS(MIN_DIGITS)) dut (
    .clk(clk), .reset(reset), .load(load), .load_min(load_min), .load_sec(load_sec),
    .start(start), .pause(pause), .auto_reload(auto_reload), .digits(digits),
    .running(running), .done(done), .done_pulse(done_pulse), .error(error)
  );

  function automatic logic [15:0] m_digits();
    return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
  endfunction

  function automatic void model_update();
    int mt, mu, st, su, t;
    if (reset) begin
      m_state = M_IDLE; m_min = 0; m_sec = 0; p_min = 0; p_sec = 0;
      m_cnt = 0; m_reload = 0; m_pulse = 0;
      return;
    end
    m_pulse = 0;
    if (load) begin
      mt = int'(load_min[7:4]); mu = int'(load_min[3:0]);
      st = int'(load_sec[7:4]); su = int'(load_sec[3:0]);
      m_reload = 0;
      if (mt <= 9 && mu <= 9 && st <= 5 && su <= 9) begin
        p_min = mt * 10 + mu; p_sec = st * 10 + su;
        m_min = p_min; m_sec = p_sec; m_cnt = 0; m_state = M_IDLE;
      end else begin
        m_min = 0; m_sec = 0; m_state = M_ERROR;
      end
    end else if (m_reload) begin
      m_reload = 0;
      if (p_min == 0 && p_sec == 0) begin
        m_min = 0; m_sec = 0; m_state = M_DONE;
      end else begin
        m_min = p_min; m_sec = p_sec; m_cnt = 0;
        m_state = pause ? M_PAUSED : M_RUN;
      end
    end else begin
      case (m_state)
        M_IDLE: if (!pause && start) begin
          if (m_min == 0 && m_sec == 0) begin m_state = M_DONE; m_pulse = 1; end
          else m_state = M_RUN;
        end
        M_RUN: begin
          if (pause) m_state = M_PAUSED;
          else if (m_cnt == TDIV - 1) begin
            m_cnt = 0;
            t = m_min * 60 + m_sec - 1;
            m_min = t / 60; m_sec = t % 60;
            if (t == 0) begin
              m_pulse = 1;
              if (auto_reload) m_reload = 1;
              else m_state = M_DONE;
            end
          end else m_cnt++;
        end
        M_PAUSED: if (!pause && start) m_state = M_RUN;
        default: ;
      endcase
    end
  endfunction

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; load = 0; start = 0; pause = 0; auto_reload = 0;
    load_min = 8'h00; load_sec = 8'h00;
    step();
    reset = 0;
  endtask

  task automatic do_load(input logic [7:0] mn, input logic [7:0] sc);
    load = 1; load_min = mn; load_sec = sc;
    step();
    load = 0;
  endtask

  task automatic do_start();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL reset_digits got=%h exp=0000", digits); end
    checks++; if ({running, done, done_pulse, error} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {running, done, done_pulse, error});
    end
  endtask

  task automatic test_countdown();
    int pulses;
    do_reset();
    do_load(8'h00, 8'h03);
    do_start();
    checks++; if (running !== 1'b1 || digits !== 16'h0003) begin
      errors++; $display("FAIL cd_start running=%b digits=%h exp=1/0003", running, digits);
    end
    pulses = 0;
    for (int k = 1; k <= 3; k++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        if (done_pulse) pulses++;
        if (c == 2) begin
          checks++; if (digits !== 16'(4 - k)) begin
            errors++; $display("FAIL cd_spacing k=%0d digits=%h exp=%h", k, digits, 16'(4 - k));
          end
        end
      end
      checks++; if (digits !== 16'(3 - k)) begin
        errors++; $display("FAIL cd_tick k=%0d digits=%h exp=%h", k, digits, 16'(3 - k));
      end
    end
    checks++; if (done_pulse !== 1'b1 || pulses != 1) begin
      errors++; $display("FAIL cd_pulse pulse=%b count=%0d exp=1/1", done_pulse, pulses);
    end
    checks++; if (done !== 1'b1 || running !== 1'b0) begin
      errors++; $display("FAIL cd_done done=%b running=%b exp=1/0", done, running);
    end
    start = 1; pause = 1;
    step();
    start = 0; pause = 0;
    checks++; if (done_pulse !== 1'b0 || done !== 1'b1 || digits !== 16'h0000) begin
      errors++; $display("FAIL cd_hold pulse=%b done=%b digits=%h exp=0/1/0000", done_pulse, done, digits);
    end
  endtask

  task automatic test_borrow();
    do_reset();
    do_load(8'h10, 8'h00);
    do_start();
    repeat (4) step();
    checks++; if (digits !== 16'h0959) begin errors++; $display("FAIL borrow_min digits=%h exp=0959", digits); end
    do_load(8'h99, 8'h59);
    do_start();
    repeat (4) step();
    checks++; if (digits !== 16'h9958 || running !== 1'b1) begin
      errors++; $display("FAIL full_scale digits=%h running=%b exp=9958/1", digits, running);
    end
  endtask

  task automatic test_error();
    do_reset();
    do_load(8'h01, 8'h70);
    checks++; if (error !== 1'b1 || digits !== 16'h0000) begin
      errors++; $display("FAIL err_load error=%b digits=%h exp=1/0000", error, digits);
    end
    do_start();
    checks++; if (error !== 1'b1 || running !== 1'b0) begin
      errors++; $display("FAIL err_start error=%b running=%b exp=1/0", error, running);
    end
    do_load(8'h00, 8'h05);
    checks++; if ({error, running, done} !== 3'b000 || digits !== 16'h0005) begin
      errors++; $display("FAIL err_exit flags=%b digits=%h exp=000/0005", {error, running, done}, digits);
    end
    do_load(8'hA0, 8'h00);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_min_nibble error=%b exp=1", error); end
    do_load(8'h00, 8'h0A);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_sec_units error=%b exp=1", error); end
    do_load(8'h09, 8'h59);
    checks++; if (error !== 1'b0 || digits !== 16'h0959) begin
      errors++; $display("FAIL err_max_valid error=%b digits=%h exp=0/0959", error, digits);
    end
  endtask

  task automatic test_zero_start();
    do_reset();
    auto_reload = 1;
    do_load(8'h00, 8'h00);
    do_start();
    checks++; if ({done, done_pulse, running} !== 3'b110) begin
      errors++; $display("FAIL zero_start flags=%b exp=110", {done, done_pulse, running});
    end
    repeat (6) step();
    checks++; if ({done, done_pulse, running} !== 3'b100) begin
      errors++; $display("FAIL zero_no_loop flags=%b exp=100", {done, done_pulse, running});
    end
    auto_reload = 0;
  endtask

  task automatic test_auto_reload();
    int pulses;
    bit saw_done;
    do_reset();
    auto_reload = 1;
    do_load(8'h00, 8'h02);
    do_start();
    pulses = 0; saw_done = 0;
    for (int s = 1; s <= 18; s++) begin
      step();
      if (done_pulse) pulses++;
      if (done) saw_done = 1;
      if (s == 8 || s == 17) begin
        checks++; if (digits !== 16'h0000 || done_pulse !== 1'b1) begin
          errors++; $display("FAIL ar_expire s=%0d digits=%h pulse=%b exp=0000/1", s, digits, done_pulse);
        end
      end
      if (s == 9) begin
        checks++; if (digits !== 16'h0002 || running !== 1'b1) begin
          errors++; $display("FAIL ar_reload digits=%h running=%b exp=0002/1", digits, running);
        end
      end
      if (s == 13) begin
        checks++; if (digits !== 16'h0001) begin errors++; $display("FAIL ar_retick digits=%h exp=0001", digits); end
      end
    end
    checks++; if (pulses != 2 || saw_done) begin
      errors++; $display("FAIL ar_summary pulses=%0d done_seen=%0d exp=2/0", pulses, saw_done);
    end
    auto_reload = 0;
  endtask

  task automatic test_pause_resume();
    do_reset();
    do_load(8'h00, 8'h05);
    do_start();
    repeat (2) step();
    pause = 1;
    repeat (10) step();
    pause = 0;
    checks++; if (running !== 1'b0 || digits !== 16'h0005) begin
      errors++; $display("FAIL pause_hold running=%b digits=%h exp=0/0005", running, digits);
    end
    do_start();
    checks++; if (running !== 1'b1 || digits !== 16'h0005) begin
      errors++; $display("FAIL resume running=%b digits=%h exp=1/0005", running, digits);
    end
    step();
    checks++; if (digits !== 16'h0005) begin errors++; $display("FAIL resume_early digits=%h exp=0005", digits); end
    step();
    checks++; if (digits !== 16'h0004) begin errors++; $display("FAIL resume_tick digits=%h exp=0004", digits); end
  endtask

  task automatic test_load_on_tick();
    do_reset();
    do_load(8'h00, 8'h05);
    do_start();
    repeat (3) step();
    do_load(8'h00, 8'h30);
    checks++; if (digits !== 16'h0030 || running !== 1'b0 || done_pulse !== 1'b0) begin
      errors++; $display("FAIL load_on_tick digits=%h running=%b pulse=%b exp=0030/0/0", digits, running, done_pulse);
    end
    do_start();
    pause = 1; start = 1;
    step();
    pause = 0; start = 0;
    checks++; if (running !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL pause_start_run running=%b done=%b exp=0/0", running, done);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    do_reset();
    do_load(8'h00, 8'h05);
    do_start();
    repeat (11) step();
    checks++; if (digits !== 16'h0003) begin errors++; $display("FAIL rm_pre digits=%h exp=0003", digits); end
    reset = 1;
    step();
    reset = 0;
    checks++; if (digits !== 16'h0000 || {running, done, done_pulse, error} !== 4'b0000) begin
      errors++; $display("FAIL rm_abort digits=%h flags=%b exp=0000/0000", digits, {running, done, done_pulse, error});
    end
    pulses = 0;
    repeat (6) begin step(); if (done_pulse || running) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rm_quiet events=%0d exp=0", pulses); end
  endtask

  task automatic test_random();
    logic [15:0] w;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      load  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) begin
        w = 16'($urandom);
        load_min = w[15:8]; load_sec = w[7:0];
      end else begin
        load_min = {4'h0, 4'($urandom_range(0, 1))};
        load_sec = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
      end
      pause = ($urandom_range(0, 11) == 0);
      start = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 49) == 0) auto_reload = ~auto_reload;
      step();
      checks++; if (digits !== m_digits()) begin
        errors++; $display("FAIL rnd_digits i=%0d got=%h exp=%h", i, digits, m_digits());
      end
      checks++; if ({running, done, done_pulse, error} !==
                    {m_state == M_RUN, m_state == M_DONE, m_pulse, m_state == M_ERROR}) begin
        errors++; $display("FAIL rnd_flags i=%0d got=%b exp=%b", i, {running, done, done_pulse, error},
                           {m_state == M_RUN, m_state == M_DONE, m_pulse, m_state == M_ERROR});
      end
    end
    reset = 0; load = 0; start = 0; pause = 0; auto_reload = 0;
  endtask

  initial begin
    reset = 1; load = 0; start = 0; pause = 0; auto_reload = 0;
    load_min = 8'h00; load_sec = 8'h00;
    test_reset();
    test_countdown();
    test_borrow();
    test_error();
    test_zero_start();
    test_auto_reload();
    test_pause_resume();
    test_load_on_tick();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
